fp_mod_reduce_pipe: RTL and testbench

- Conditional-subtraction reduction stage placed directly downstream of the split-carry Fp adder in the BN254 datapath.
- Consumes an unreduced sum S in [0, 2·MOD) and produces S mod MOD: S−MOD when S ≥ MOD, else S.
- The subtraction is split into two half-width limbs, matching the adder's half-split carry scheme, to meet timing at 256 bits.
- Fully pipelined, 2-stage, valid/ready handshake with backpressure, so it can sit between the adder and the multiplier input queue.

---
 rtl/fp_mod_reduce_pipe_if.sv | 22 ++
 rtl/fp_mod_reduce_pipe.sv | 70 +++++++
 tb/tb_fp_mod_reduce_pipe.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fp_mod_reduce_pipe_if.sv
// Handshake bundle for the Fp conditional-subtraction stage: input stream, output stream, error flag.
interface fp_mod_reduce_pipe_if #(
  parameter int W = 256
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/fp_mod_reduce_pipe.sv
// Two-stage S mod p reduction for S in [0, 2p): limb-split subtraction in S1, borrow combine and select in S2.
module fp_mod_reduce_pipe #(
  parameter int           W   = 256,
  parameter logic [W-1:0] MOD = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47
) (
  input  logic               clk,
  input  logic               rst,
  fp_mod_reduce_pipe_if.slave bus
);
  localparam int HALF = W / 2;

  typedef struct packed {
    logic [W-1:0]  s;
    logic [HALF:0] dl;
    logic [HALF:0] dh;
  } s1_t;

  s1_t          s1_q, s1_d;
  logic         v1_q, v2_q;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_err_q, out_err_d;
  logic         adv1, adv2;
  logic [HALF-1:0] hi_sub;
  logic [W-1:0] d_full;
  logic         borrow;

  // Ready is combinational from out_ready so a full pipe still streams one per cycle.
  assign adv2        = !v2_q || bus.out_ready;
  assign adv1        = !v1_q || adv2;
  assign bus.in_ready  = adv1;
  assign bus.out_valid = v2_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

  always_comb begin
    s1_d    = '0;
    s1_d.s  = bus.in_data;
    s1_d.dl = {1'b0, bus.in_data[HALF-1:0]} - {1'b0, MOD[HALF-1:0]};
    s1_d.dh = {1'b0, bus.in_data[W-1:HALF]} - {1'b0, MOD[W-1:HALF]};
  end

  // A low-limb borrow only sinks the whole result when the high difference is exactly zero.
  always_comb begin
    hi_sub     = s1_q.dh[HALF-1:0] - HALF'(s1_q.dl[HALF]);
    d_full     = {hi_sub, s1_q.dl[HALF-1:0]};
    borrow     = s1_q.dh[HALF] | ((s1_q.dh[HALF-1:0] == '0) && s1_q.dl[HALF]);
    out_data_d = borrow ? s1_q.s : d_full;
    out_err_d  = !borrow && (d_full >= MOD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      if (adv1) v1_q <= bus.in_valid;
      if (adv2) v2_q <= v1_q;
      if (adv2 && v1_q) begin
        out_data_q <= out_data_d;
        out_err_q  <= out_err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) s1_q <= s1_d;
  end
endmodule

// File: tb/tb_fp_mod_reduce_pipe.sv
// Directed table plus corner sequences and a random stream, all scored against an S mod p model.
module tb_fp_mod_reduce_pipe;
  localparam logic [255:0] MOD  = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
  localparam logic [255:0] MOD2 = MOD + MOD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mod_reduce_pipe_if #(.W(256)) bus ();
  fp_mod_reduce_pipe #(.W(256), .MOD(MOD)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [255:0] s;
    logic [255:0] exp;
    logic         err;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    logic         err;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_out = 0;
  exp_t sbq[$];
  int   out_cycs[$];
  vec_t vec[12];

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive at negedge, settle, then decide both transfers for the coming posedge.
  task automatic step(input bit iv, input logic [255:0] d, input logic [255:0] ed, input bit ee,
                      input bit ordy, output bit took_in, output bit took_out);
    exp_t e;
    @(negedge clk);
    cyc++;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    took_in  = iv && bus.in_ready;
    took_out = bus.out_valid && ordy;
    if (took_out) begin
      n_out++;
      out_cycs.push_back(cyc);
      if (sbq.size() == 0) begin
        chk("unexpected_out", 256'(bus.out_valid), 256'd0);
      end else begin
        e = sbq.pop_front();
        chk("out_err", 256'(bus.out_err), 256'(e.err));
        if (!e.err) chk("out_data", bus.out_data, e.data);
      end
    end
    if (took_in) begin
      e.data = ed;
      e.err  = ee;
      sbq.push_back(e);
    end
  endtask

  function automatic exp_t model(logic [255:0] s);
    exp_t e;
    e.err  = (s >= MOD2);
    e.data = (s >= MOD) ? s - MOD : s;
    return e;
  endfunction

  task automatic drain();
    bit ti, to;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1, ti, to);
    chk("drain_left", 256'(sbq.size()), 256'd0);
  endtask

  initial begin
    logic [255:0] modl, modh, s;
    exp_t e;
    bit   ti, to;
    int   c0, acc, n0;

    modl = 256'(MOD[127:0]);
    modh = 256'(MOD[255:128]);
    vec[0]  = '{256'd0, 256'd0, 1'b0};
    vec[1]  = '{256'd5, 256'd5, 1'b0};
    vec[2]  = '{MOD - 256'd1, MOD - 256'd1, 1'b0};
    vec[3]  = '{MOD, 256'd0, 1'b0};
    vec[4]  = '{MOD + 256'd1, 256'd1, 1'b0};
    vec[5]  = '{MOD2 - 256'd1, MOD - 256'd1, 1'b0};
    vec[6]  = '{{modh[127:0], {128{1'b1}}}, {128'd0, ~modl[127:0]}, 1'b0};
    vec[7]  = '{{modh[127:0] + 128'd1, 128'd0}, {128'd0, (~modl[127:0]) + 128'd1}, 1'b0};
    vec[8]  = '{{modh[127:0], 128'd0}, {modh[127:0], 128'd0}, 1'b0};
    vec[9]  = '{MOD2 + 256'd7, 256'd0, 1'b1};
    vec[10] = '{MOD2, 256'd0, 1'b1};
    vec[11] = '{256'd1 << 255, 256'd0, 1'b1};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
    chk("rst_out_err", 256'(bus.out_err), 256'd0);
    chk("rst_out_data", bus.out_data, 256'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_in_ready", 256'(bus.in_ready), 256'd1);

    // Latency: S=5 accepted, result two cycles later.
    out_cycs.delete();
    step(1'b1, 256'd5, 256'd5, 1'b0, 1'b1, ti, to);
    c0 = cyc;
    chk("lat_accept", 256'(ti), 256'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, ti, to);
    chk("lat_count", 256'(out_cycs.size()), 256'd1);
    if (out_cycs.size() > 0) chk("lat_cycles", 256'(out_cycs[0] - c0), 256'd2);

    // Back-to-back MOD, MOD-1, 2MOD-1 with no bubbles.
    out_cycs.delete();
    step(1'b1, vec[3].s, vec[3].exp, 1'b0, 1'b1, ti, to);
    step(1'b1, vec[2].s, vec[2].exp, 1'b0, 1'b1, ti, to);
    step(1'b1, vec[5].s, vec[5].exp, 1'b0, 1'b1, ti, to);
    drain();
    chk("b2b_count", 256'(out_cycs.size()), 256'd3);
    if (out_cycs.size() == 3) chk("b2b_span", 256'(out_cycs[2] - out_cycs[0]), 256'd2);

    // Full table streamed with out_ready high.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vec[i].s, vec[i].exp, vec[i].err, 1'b1, ti, to);
      chk("tbl_accept", 256'(ti), 256'd1);
    end
    drain();

    // Backpressure: only two accepts while stalled, output held at 1.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 256'(acc + 1), 256'(acc + 1), 1'b0, 1'b0, ti, to);
      if (ti) acc++;
      if (bus.out_valid) chk("bp_hold", bus.out_data, 256'd1);
    end
    chk("bp_accepts", 256'(acc), 256'd2);
    chk("bp_in_ready", 256'(bus.in_ready), 256'd0);
    for (int i = 0; i < 20 && acc < 4; i++) begin
      step(1'b1, 256'(acc + 1), 256'(acc + 1), 1'b0, 1'b1, ti, to);
      if (ti) acc++;
    end
    chk("bp_total", 256'(acc), 256'd4);
    drain();

    // Async reset while full and stalled.
    step(1'b1, 256'd10, 256'd10, 1'b0, 1'b0, ti, to);
    step(1'b1, 256'd11, 256'd11, 1'b0, 1'b0, ti, to);
    step(1'b0, '0, '0, 1'b0, 1'b0, ti, to);
    chk("pre_rst_valid", 256'(bus.out_valid), 256'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 256'(bus.out_valid), 256'd0);
    chk("async_rst_data", bus.out_data, 256'd0);
    @(negedge clk); rst = 1'b0; sbq.delete(); #1;
    chk("post_rst_in_ready", 256'(bus.in_ready), 256'd1);
    n0 = n_out;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, ti, to);
    chk("no_stale", 256'(n_out - n0), 256'd0);

    // Random stream with random valid/ready.
    s = '0;
    for (int i = 0; i < 8; i++) s = {s[223:0], 32'($urandom)};
    s[255] = 1'b0;
    if (s >= MOD2) s = s - MOD2;
    n0 = n_out;
    acc = 0;
    for (int i = 0; i < 3000; i++) begin
      e = model(s);
      step($urandom_range(0, 3) != 0, s, e.data, e.err, $urandom_range(0, 3) != 0, ti, to);
      if (ti) begin
        acc++;
        for (int k = 0; k < 8; k++) s = {s[223:0], 32'($urandom)};
        s[255] = 1'b0;
        if (s >= MOD2) s = s - MOD2;
      end
    end
    drain();
    chk("rand_count", 256'(n_out - n0), 256'(acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
